iter_shifter: RTL and testbench

ITER_SHIFTER -- requirements
Module: iter_shifter

---
 rtl/iter_shifter.sv | 99 +++++++++
 tb/tb_iter_shifter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: captures an operand, then rotates/shifts it one bit per
// cycle until the captured count runs out, and registers the result on completion.
module iter_shifter #(
  parameter int OPERAND_WIDTH  = 16,
  parameter int SHAMT_WIDTH    = 4,
  parameter int NUM_OPERATIONS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [OPERAND_WIDTH-1:0]  In,
  input  logic [SHAMT_WIDTH-1:0]    ShAmt,
  input  logic [NUM_OPERATIONS-1:0] Oper,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic [OPERAND_WIDTH-1:0]  Out
);

  localparam int W = OPERAND_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [NUM_OPERATIONS-1:0] OP_ROR = NUM_OPERATIONS'(0);
  localparam logic [NUM_OPERATIONS-1:0] OP_SLL = NUM_OPERATIONS'(1);
  localparam logic [NUM_OPERATIONS-1:0] OP_SRA = NUM_OPERATIONS'(2);

  logic [1:0]                state_q, state_d;
  logic [W-1:0]              data_q, data_d;
  logic [SHAMT_WIDTH-1:0]    count_q, count_d;
  logic [NUM_OPERATIONS-1:0] op_q, op_d;
  logic [W-1:0]              out_q, out_d;
  logic [W-1:0]              step;

  // One-bit step for the captured operation; any code outside the first three is SRL.
  always_comb begin
    step = data_q;
    case (op_q)
      OP_ROR:  step = {data_q[0], data_q[W-1:1]};
      OP_SLL:  step = {data_q[W-2:0], 1'b0};
      OP_SRA:  step = {data_q[W-1], data_q[W-1:1]};
      default: step = {1'b0, data_q[W-1:1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    op_d    = op_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = In;
          count_d = ShAmt;
          op_d    = Oper;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Decrement only on a nonzero count, so count can never wrap.
        if (count_q != '0) begin
          data_d  = step;
          count_d = count_q - SHAMT_WIDTH'(1);
        end else begin
          out_d   = data_q;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      count_q <= '0;
      op_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_SHIFT);
  assign done  = (state_q == S_DONE);
  assign Out   = out_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: stimulus pushes expected results, a
// negedge monitor pops them on done and checks handshakes and Out every cycle.
module tb_iter_shifter;

  localparam int W  = 16;
  localparam int SW = 4;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  In = '0;
  logic [SW-1:0] ShAmt = '0;
  logic [OW-1:0] Oper = '0;
  logic          ready, busy, done;
  logic [W-1:0]  Out;

  iter_shifter #(.OPERAND_WIDTH(W), .SHAMT_WIDTH(SW), .NUM_OPERATIONS(OW)) dut (
    .clk(clk), .rst(rst), .start(start), .In(In), .ShAmt(ShAmt), .Oper(Oper),
    .ready(ready), .busy(busy), .done(done), .Out(Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] exp;
    int           c0;
    int           sh;
  } item_t;

  item_t        sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic         rst_edge = 1'b1;
  logic         mon_en = 1'b0;
  logic         prev_done = 1'b0;
  logic [W-1:0] model_out = '0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  // Reference model: whole-word arithmetic on the operand, no iteration.
  function automatic logic [W-1:0] ref_shift(logic [W-1:0] a, int s, logic [OW-1:0] op);
    logic [2*W-1:0] dbl;
    case (op)
      2'd0: begin dbl = {a, a} >> s; return dbl[W-1:0]; end
      2'd1: return a << s;
      2'd2: return W'($signed(a) >>> s);
      default: return a >> s;
    endcase
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_edge) model_out = '0;
      chk("onehot", W'($countones({ready, busy, done})), W'(1));
      if (prev_done) chk("ready_after_done", W'(ready), W'(1));
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          item_t it;
          it = sb.pop_front();
          chk("result", Out, it.exp);
          chk("latency", W'(cyc - it.c0), W'(it.sh + 2));
          model_out = it.exp;
        end
      end
      chk("out_hold", Out, model_out);
      prev_done = (done === 1'b1);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got ready=%b expected 1 within 200 cycles", ready);
    end
  endtask

  // Issue one operation; with noise, keep start high with junk until ready returns.
  task automatic do_op(logic [W-1:0] a, logic [SW-1:0] s, logic [OW-1:0] op,
                       logic [W-1:0] exp, bit noise);
    item_t it;
    wait_ready();
    start = 1'b1; In = a; ShAmt = s; Oper = op;
    it.exp = exp; it.c0 = cyc; it.sh = int'(s);
    sb.push_back(it);
    @(posedge clk); #1;
    if (noise) begin
      int n = 0;
      In = 16'hFFFF; ShAmt = SW'($urandom); Oper = OW'($urandom);
      while (ready !== 1'b1 && n < 200) begin
        @(posedge clk); #1;
        In = W'($urandom); ShAmt = SW'($urandom); Oper = OW'($urandom);
        n++;
      end
    end
    start = 1'b0;
    In = W'($urandom); ShAmt = SW'($urandom); Oper = OW'($urandom);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("reset_ready", W'(ready), W'(1));
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    chk("reset_out", Out, W'(0));
    rst = 1'b0;

    // First start lands on the first edge with rst low.
    do_op(16'h1234, 4'd4, 2'd0, 16'h4123, 1'b0);
    do_op(16'h8000, 4'd15, 2'd2, 16'hFFFF, 1'b0);
    do_op(16'h8000, 4'd15, 2'd3, 16'h0001, 1'b0);
    do_op(16'h0001, 4'd15, 2'd1, 16'h8000, 1'b0);
    for (int k = 0; k < 4; k++) do_op(16'hA5A5, 4'd0, OW'(k), 16'hA5A5, 1'b0);
    do_op(16'h8001, 4'd1, 2'd0, 16'hC000, 1'b1);
    for (int k = 0; k < 4; k++) do_op(16'h8001, 4'd1, OW'(k), ref_shift(16'h8001, 1, OW'(k)), 1'b0);

    // Abort mid-shift: no done pulse may follow, Out reads zero.
    wait_ready();
    start = 1'b1; In = 16'hFFFF; ShAmt = 4'd8; Oper = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", W'(ready), W'(1));
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_out", Out, W'(0));
    repeat (12) @(posedge clk);
    #1;

    for (int k = 0; k < 24; k++) begin
      logic [W-1:0]  a;
      logic [SW-1:0] s;
      logic [OW-1:0] op;
      a = W'($urandom); s = SW'($urandom); op = OW'($urandom);
      do_op(a, s, op, ref_shift(a, int'(s), op), bit'($urandom_range(0, 1)));
    end

    wait_ready();
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", W'(sb.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
